// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: loads a program word-by-word into a byte-wide instruction
// memory, then starts the CPU and watches for end-of-program or a cycle limit.
// Load path: IDLE accepts a word, WRITE emits its 4 bytes little-endian.
// Run path: ARMED waits for run_req, RUN enables the CPU, DONE holds the result.
module mips_run_ctrl #(
  parameter int DEPTH_WORDS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        run_req,
  input  logic [15:0] max_cycles,
  input  logic [31:0] pc,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [7:0]  im_wdata,
  output logic        cpu_start,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
  output logic [15:0] cycle_count,
  output logic [5:0]  word_count
);

  localparam logic [5:0] L_DEPTH = 6'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ARMED = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_last;
  logic [1:0]  r_byte;
  logic        r_load_ready;
  logic        r_im_we;
  logic [7:0]  r_im_addr;
  logic [7:0]  r_im_wdata;
  logic        r_cpu_start;
  logic        r_done;
  logic        r_timeout;
  logic        r_overflow;
  logic [15:0] r_cycle_count;
  logic [5:0]  r_word_count;

  logic        w_full;
  logic [31:0] w_end_addr;
  logic        w_end_reached;
  logic [16:0] w_cc_inc;
  logic [15:0] w_cc_sat;
  logic        w_limit_hit;
  logic [5:0]  w_wc_inc;
  logic [1:0]  w_byte_nxt;

  // Little-endian byte lane select of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] res;
    case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = 8'd0;
    endcase
    return res;
  endfunction

  // Derived conditions: memory full, end-of-program address, cycle arithmetic.
  always_comb begin
    w_full        = (r_word_count >= L_DEPTH);
    w_end_addr    = {24'd0, r_word_count, 2'b00};
    w_end_reached = (pc >= w_end_addr);
    w_cc_inc      = {1'b0, r_cycle_count} + 17'd1;
    w_cc_sat      = (r_cycle_count == 16'hFFFF) ? 16'hFFFF : w_cc_inc[15:0];
    // 17-bit compare so a saturated counter can never alias onto the limit
    w_limit_hit   = (max_cycles != 16'd0) && (w_cc_inc == {1'b0, max_cycles});
    w_wc_inc      = r_word_count + 6'd1;
    w_byte_nxt    = r_byte + 2'd1;
  end

  // Controller FSM; every output is a register updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_data        <= 32'd0;
      r_last        <= 1'b0;
      r_byte        <= 2'd0;
      r_load_ready  <= 1'b1;
      r_im_we       <= 1'b0;
      r_im_addr     <= 8'd0;
      r_im_wdata    <= 8'd0;
      r_cpu_start   <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_cycle_count <= 16'd0;
      r_word_count  <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid && r_load_ready) begin
            r_data       <= load_data;
            r_last       <= load_last;
            r_byte       <= 2'd0;
            r_im_we      <= 1'b1;
            r_im_addr    <= {r_word_count, 2'b00};
            r_im_wdata   <= load_data[7:0];
            r_load_ready <= 1'b0;
            r_state      <= WRITE;
          end else if (load_valid && w_full) begin
            // word is dropped; only the sticky flag records it
            r_overflow <= 1'b1;
          end else begin
            r_load_ready <= ~w_full;
          end
        end
        WRITE: begin
          if (r_byte != 2'd3) begin
            r_byte     <= w_byte_nxt;
            r_im_addr  <= {r_word_count, w_byte_nxt};
            r_im_wdata <= byte_sel(r_data, w_byte_nxt);
          end else begin
            r_im_we      <= 1'b0;
            r_im_addr    <= 8'd0;
            r_im_wdata   <= 8'd0;
            r_byte       <= 2'd0;
            r_word_count <= w_wc_inc;
            if (r_last) begin
              r_load_ready <= 1'b0;
              r_state      <= ARMED;
            end else begin
              r_load_ready <= (w_wc_inc < L_DEPTH);
              r_state      <= IDLE;
            end
          end
        end
        ARMED: begin
          if (run_req) begin
            r_cycle_count <= 16'd0;
            r_cpu_start   <= 1'b1;
            r_state       <= RUN;
          end else begin
            r_cpu_start <= 1'b0;
          end
        end
        RUN: begin
          r_cycle_count <= w_cc_sat;
          // end-of-program wins over the cycle limit
          if (w_end_reached) begin
            r_cpu_start <= 1'b0;
            r_done      <= 1'b1;
            r_timeout   <= 1'b0;
            r_state     <= DONE;
          end else if (w_limit_hit) begin
            r_cpu_start <= 1'b0;
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cpu_start <= 1'b1;
          end
        end
        DONE: begin
          if (run_req) begin
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= 16'd0;
            r_cpu_start   <= 1'b1;
            r_state       <= RUN;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          // illegal encoding: fall back to a quiet IDLE
          r_state      <= IDLE;
          r_im_we      <= 1'b0;
          r_cpu_start  <= 1'b0;
          r_load_ready <= ~w_full;
        end
      endcase
    end
  end

  assign load_ready  = r_load_ready;
  assign im_we       = r_im_we;
  assign im_addr     = r_im_addr;
  assign im_wdata    = r_im_wdata;
  assign cpu_start   = r_cpu_start;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: load, run, limit, overflow and reset cases.
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        run_req = 1'b0;
  logic [15:0] max_cycles = 16'd0;
  logic [31:0] pc = 32'd0;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [7:0]  im_wdata;
  logic        cpu_start;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [15:0] cycle_count;
  logic [5:0]  word_count;

  int total = 0;
  int bad = 0;

  localparam logic [43:0] RESET_VEC = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,
                                       1'b0, 1'b0, 16'h0000, 6'd0};

  mips_run_ctrl #(.DEPTH_WORDS(50)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .run_req(run_req), .max_cycles(max_cycles), .pc(pc),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_start(cpu_start), .done(done), .timeout(timeout), .overflow(overflow),
    .cycle_count(cycle_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got stalled run want finish");
    $fatal(1, "bench stalled");
  end

  function automatic logic [43:0] out_vec();
    return {load_ready, im_we, im_addr, im_wdata, cpu_start, done, timeout,
            overflow, cycle_count, word_count};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0;
    run_req = 1'b0; max_cycles = 16'd0; pc = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // called at a negedge in IDLE; returns at the negedge after the 4th byte completes
  task automatic load_word(input logic [31:0] d, input logic l);
    load_valid = 1'b1; load_data = d; load_last = l;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] mc);
    max_cycles = mc; run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_vec() !== RESET_VEC) begin
      bad++; $display("FAIL reset_state: got %h want %h", out_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req = 1'b1;
    repeat (2) @(negedge clk);
    run_req = 1'b0;
    total++;
    if ({cpu_start, load_ready, done} !== 3'b010) begin
      bad++; $display("FAIL idle_run_req_ignored: got %b want 010", {cpu_start, load_ready, done});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4] = '{8'h04, 8'h00, 8'h01, 8'h8C};
    do_reset();
    load_valid = 1'b1; load_data = 32'h8C010004; load_last = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      load_valid = 1'b0; load_last = 1'b0;
      total++;
      if ({im_we, im_addr, im_wdata} !== {1'b1, 8'(b), exp_b[b]}) begin
        bad++; $display("FAIL write_byte%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                        b, im_we, im_addr, im_wdata, 8'(b), exp_b[b]);
      end
    end
    @(negedge clk);
    total++;
    if ({im_we, load_ready, word_count} !== {1'b0, 1'b0, 6'd1}) begin
      bad++; $display("FAIL armed_after_last: got we=%b rdy=%b wc=%0d want 0 0 1", im_we, load_ready, word_count);
    end
    load_valid = 1'b1; load_data = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    load_valid = 1'b0;
    total++;
    if ({im_we, word_count, overflow} !== {1'b0, 6'd1, 1'b0}) begin
      bad++; $display("FAIL armed_load_ignored: got we=%b wc=%0d ovf=%b want 0 1 0", im_we, word_count, overflow);
    end
  endtask

  task automatic test_run_end();
    do_reset();
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b0);
    load_word(32'h33333333, 1'b1);
    total++;
    if (word_count !== 6'd3) begin
      bad++; $display("FAIL three_words: got %0d want 3", word_count);
    end
    start_run(16'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({cpu_start, done, cycle_count} !== {1'b1, 1'b0, 16'(i)}) begin
        bad++; $display("FAIL run_cycle%0d: got start=%b done=%b cc=%0d want 1 0 %0d", i, cpu_start, done, cycle_count, i);
      end
      pc = 32'(i * 4);
      @(negedge clk);
    end
    total++;
    if ({cpu_start, done, timeout, cycle_count} !== {1'b0, 1'b1, 1'b0, 16'd4}) begin
      bad++; $display("FAIL end_reached: got start=%b done=%b to=%b cc=%0d want 0 1 0 4", cpu_start, done, timeout, cycle_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load_word(32'h8C010004, 1'b1);
    pc = 32'd0;
    start_run(16'd5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cpu_start, done, cycle_count} !== {1'b1, 1'b0, 16'(i)}) begin
        bad++; $display("FAIL limit_cycle%0d: got start=%b done=%b cc=%0d want 1 0 %0d", i, cpu_start, done, cycle_count, i);
      end
      @(negedge clk);
    end
    total++;
    if ({cpu_start, done, timeout, cycle_count} !== {1'b0, 1'b1, 1'b1, 16'd5}) begin
      bad++; $display("FAIL limit_done: got start=%b done=%b to=%b cc=%0d want 0 1 1 5", cpu_start, done, timeout, cycle_count);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    load_word(32'h8C010004, 1'b1);
    pc = 32'd0;
    start_run(16'd3);
    for (int i = 0; i < 3; i++) begin
      pc = (i == 2) ? 32'd4 : 32'd0;
      @(negedge clk);
    end
    total++;
    if ({done, timeout, cycle_count} !== {1'b1, 1'b0, 16'd3}) begin
      bad++; $display("FAIL tie_priority: got done=%b to=%b cc=%0d want 1 0 3", done, timeout, cycle_count);
    end
    start_run(16'd3);
    total++;
    if ({cpu_start, done, timeout, cycle_count, word_count} !== {1'b1, 1'b0, 1'b0, 16'd0, 6'd1}) begin
      bad++; $display("FAIL rerun: got start=%b done=%b to=%b cc=%0d wc=%0d want 1 0 0 0 1",
                      cpu_start, done, timeout, cycle_count, word_count);
    end
    @(negedge clk);
    total++;
    if ({done, cycle_count} !== {1'b1, 16'd1}) begin
      bad++; $display("FAIL rerun_end: got done=%b cc=%0d want 1 1", done, cycle_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 50; i++) load_word(32'(i), 1'b0);
    total++;
    if ({load_ready, word_count, overflow} !== {1'b0, 6'd50, 1'b0}) begin
      bad++; $display("FAIL full_state: got rdy=%b wc=%0d ovf=%b want 0 50 0", load_ready, word_count, overflow);
    end
    load_valid = 1'b1; load_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({im_we, load_ready} !== 2'b00) begin
        bad++; $display("FAIL full_no_write%0d: got we=%b rdy=%b want 0 0", i, im_we, load_ready);
      end
    end
    load_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({overflow, word_count} !== {1'b1, 6'd50}) begin
      bad++; $display("FAIL overflow_sticky: got ovf=%b wc=%0d want 1 50", overflow, word_count);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    load_valid = 1'b1; load_data = 32'hA1B2C3D4; load_last = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd2, 8'hB2}) begin
      bad++; $display("FAIL byte2_before_reset: got we=%b addr=%h data=%h want 1 02 b2", im_we, im_addr, im_wdata);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_vec() !== RESET_VEC) begin
      bad++; $display("FAIL reset_mid_write: got %h want %h", out_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (out_vec() !== RESET_VEC) begin
      bad++; $display("FAIL no_resume_after_reset: got %h want %h", out_vec(), RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_run_end();
    test_timeout();
    test_same_cycle();
    test_overflow();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 50, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, active on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_valid, input, 1 bit: a program word is offered.
REQ-005 SHALL have port load_data, input, 32 bits: the instruction word.
REQ-006 SHALL have port load_last, input, 1 bit: the offered word is the final word of the program.
REQ-007 SHALL have port load_ready, output, 1 bit: the controller accepts a word this cycle.
REQ-008 SHALL have port run_req, input, 1 bit: request to start or restart execution.
REQ-009 SHALL have port max_cycles, input, 16 bits: run-cycle limit; 0 means no limit.
REQ-010 SHALL have port pc, input, 32 bits: the CPU program counter.
REQ-011 SHALL have port im_we, output, 1 bit: instruction-memory byte write enable.
REQ-012 SHALL have port im_addr, output, 8 bits: instruction-memory byte address.
REQ-013 SHALL have port im_wdata, output, 8 bits: instruction-memory write byte.
REQ-014 SHALL have port cpu_start, output, 1 bit: CPU enable.
REQ-015 SHALL have port done, output, 1 bit: run finished.
REQ-016 SHALL have port timeout, output, 1 bit: run ended on the cycle limit.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, word offered while memory was full.
REQ-018 SHALL have port cycle_count, output, 16 bits: number of run cycles elapsed.
REQ-019 SHALL have port word_count, output, 6 bits: number of words loaded.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, ARMED, RUN, DONE.
REQ-021 SHALL, in IDLE, drive load_ready=1 only when word_count<DEPTH_WORDS; load_ready SHALL be 0 in all other states.
REQ-022 SHALL, on load_valid&&load_ready, latch load_data and load_last and move to WRITE with byte index 0.
REQ-023 SHALL, in WRITE, drive im_we=1 for exactly 4 cycles with im_addr=word_count*4+b and im_wdata=load_data[8b+7:8b] for b=0..3 (little-endian).
REQ-024 SHALL, after byte 3, increment word_count, then go to ARMED if the latched load_last=1, else to IDLE.
REQ-025 SHALL set overflow=1 when load_valid=1 in IDLE while word_count==DEPTH_WORDS; the word SHALL be dropped and no write SHALL occur.
REQ-026 SHALL, in ARMED, move to RUN on run_req=1 and clear cycle_count to 0; run_req SHALL be ignored in IDLE, WRITE, and RUN.
REQ-027 SHALL drive cpu_start=1 in RUN only, and drive im_we=0 outside WRITE.
REQ-028 SHALL, in RUN, increment cycle_count every cycle, saturating at 0xFFFF.
REQ-029 SHALL, in RUN, go to DONE when pc >= word_count*4 (end reached), leaving timeout=0.
REQ-030 SHALL, in RUN with max_cycles!=0, go to DONE with timeout=1 when cycle_count+1==max_cycles, i.e. after max_cycles RUN cycles.
REQ-031 SHALL give end-reached priority when end-reached and the limit occur in the same cycle (timeout=0).
REQ-032 SHALL, in DONE, hold done=1 and cpu_start=0; run_req SHALL re-enter RUN, clearing done, timeout, and cycle_count, with the program retained.
REQ-033 SHALL require reset to load a new program after ARMED; load_valid SHALL be ignored in ARMED, RUN, and DONE.

Reset
REQ-034 SHALL, on rst_n=0, immediately (asynchronously) enter IDLE and drive load_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_start=0, done=0, timeout=0, overflow=0, cycle_count=0, word_count=0.
REQ-035 SHALL, on reset asserted mid-WRITE or mid-RUN, abort the operation without completing any further byte write; the partial program is discarded.

Verification
REQ-036 SHALL cover: load 0x8C010004 with load_last=1 -> writes addr 0..3 = 04,00,01,8C on 4 consecutive cycles; ARMED; word_count=1.
REQ-037 SHALL cover: 3-word program, run_req, pc driven 0,4,8,12 -> cpu_start high for 4 cycles; done=1, timeout=0, cycle_count=4.
REQ-038 SHALL cover: max_cycles=5 with pc held at 0 -> DONE after 5 RUN cycles; timeout=1, cycle_count=5.
REQ-039 SHALL cover: 50 words loaded without last, then load_valid=1 -> load_ready=0, overflow=1, no im_we.
REQ-040 SHALL cover: rst_n=0 during byte 2 of WRITE -> im_we=0 at once; word_count=0; all outputs at reset values.
REQ-041 SHALL cover: end-reached and limit on the same cycle -> done=1, timeout=0; then run_req -> RUN again with cycle_count=0.
